serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract engine that time-multiplexes one 1-bit full adder cell over WIDTH-bit operands. It instantiates a single `full_adder_bh` cell (ports s, cout, a, b, cin) and wraps it with:
- operand shift registers
- a carry flip-flop
- a bit counter
- a start/done handshake FSM

It is the sequencing layer that turns the team's 1-bit adder into a multi-bit arithmetic unit for area-constrained designs.

---
 rtl/serial_adder_ctrl_if.sv | 25 ++
 rtl/serial_adder_ctrl.sv | 109 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - start/done handshake and operand/result bundle for the serial adder
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output ready, busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract engine around one 1-bit full adder cell
module full_adder_bh (
  output logic s,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  // Plain 1-bit full adder.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    count;
  logic             carry;
  logic             cout_reg;
  logic             ovf_reg;
  logic             cell_s;
  logic             cell_cout;

  full_adder_bh u_cell (
    .s    (cell_s),
    .cout (cell_cout),
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state: accept start only in IDLE, leave RUN after the MSB step, DONE lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (count == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load operands on accept (inverted B plus carry-in for subtract), then one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      sum_reg  <= '0;
      count    <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            count <= '0;
          end
        end
        RUN: begin
          sum_reg <= {cell_s, sum_reg[WIDTH-1:1]};
          carry   <= cell_cout;
          op_a    <= op_a >> 1;
          op_b    <= op_b >> 1;
          if (count == LAST) begin
            // carry still holds the carry into the MSB at this point
            cout_reg <= cell_cout;
            ovf_reg  <= carry ^ cell_cout;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_reg;
  assign bus.cout  = cout_reg;
  assign bus.ovf   = ovf_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                output logic [7:0] s, output logic c, output logic v);
    int ua, ub, r, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r > 255);
      sr = sa + sb;
    end
    s = r[7:0];
    v = (sr > 127) || (sr < -128);
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub, input string tag,
                        output logic [7:0] s, output logic c, output logic v);
    int n;
    int busy_n;
    bit seen;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    tick;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    bus.sub   = 1'($urandom);
    busy_n = 0;
    seen   = 0;
    n      = 0;
    while (!seen && n < 20) begin
      if (bus.busy) busy_n++;
      if (bus.done) seen = 1;
      else begin
        tick;
        n++;
      end
    end
    check({tag, " done_latency"}, n, WIDTH);
    check({tag, " busy_cycles"}, busy_n, WIDTH);
    s = bus.sum;
    c = bus.cout;
    v = bus.ovf;
    tick;
    check({tag, " done_single"}, bus.done, 1'b0);
    check({tag, " ready_after"}, bus.ready, 1'b1);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.ready && n < 30) begin
      tick;
      n++;
    end
    check({tag, " ready_timeout"}, bus.ready, 1'b1);
  endtask

  initial begin
    vec_t       vecs[6];
    logic [7:0] s, es;
    logic       c, v, ec, ev;
    int         done_cnt;
    int         done_at[$];
    logic [7:0] done_sum[$];

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick;
    tick;
    check("reset ready", bus.ready, 1'b1);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset sum", bus.sum, 8'h00);
    check("reset cout", bus.cout, 1'b0);
    check("reset ovf", bus.ovf, 1'b0);
    rst = 1'b0;
    tick;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, $sformatf("vec%0d", i), s, c, v);
      check($sformatf("vec%0d sum", i), s, vecs[i].sum);
      check($sformatf("vec%0d cout", i), c, vecs[i].cout);
      check($sformatf("vec%0d ovf", i), v, vecs[i].ovf);
    end

    // start pulsed mid-run must be ignored
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.sub = 1'b0;
    tick;
    bus.start = 1'b0;
    tick; tick; tick;
    bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
    tick;
    bus.start = 1'b0;
    done_cnt = 0;
    s = 8'h00;
    for (int k = 0; k < 25; k++) begin
      if (bus.done) begin
        done_cnt++;
        s = bus.sum;
      end
      tick;
    end
    check("busy_start done_count", done_cnt, 1);
    check("busy_start sum", s, 8'h30);
    check("busy_start ready", bus.ready, 1'b1);

    // start held high: accepted again on the first ready cycle
    bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'hF0; bus.sub = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (bus.done) begin
        done_at.push_back(k);
        done_sum.push_back(bus.sum);
      end
    end
    bus.start = 1'b0;
    check("b2b done_count", done_at.size(), 4);
    for (int k = 0; k < done_at.size(); k++) begin
      check($sformatf("b2b sum%0d", k), done_sum[k], 8'hFF);
      if (k > 0) check($sformatf("b2b spacing%0d", k), done_at[k] - done_at[k-1], 10);
    end
    wait_ready("b2b");
    tick;

    // reset after four bit steps aborts with no done
    bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h33; bus.sub = 1'b0;
    tick;
    bus.start = 1'b0;
    tick; tick; tick; tick;
    rst = 1'b1;
    tick;
    check("abort ready", bus.ready, 1'b1);
    check("abort busy", bus.busy, 1'b0);
    check("abort sum", bus.sum, 8'h00);
    check("abort done", bus.done, 1'b0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done) done_cnt++;
      tick;
    end
    check("abort no_done", done_cnt, 0);
    run_op(8'h03, 8'h04, 1'b0, "post_abort", s, c, v);
    check("post_abort sum", s, 8'h07);

    // randomized operations against the arithmetic model
    for (int k = 0; k < 30; k++) begin
      logic [7:0] ra, rb;
      logic       rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, es, ec, ev);
      run_op(ra, rb, rs, $sformatf("rnd%0d", k), s, c, v);
      check($sformatf("rnd%0d sum a=%0h b=%0h sub=%0d", k, ra, rb, rs), s, es);
      check($sformatf("rnd%0d cout", k), c, ec);
      check($sformatf("rnd%0d ovf", k), v, ev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
